fetch_sequencer: RTL and testbench
==================================

FETCH_SEQUENCER -- requirements
Module: fetch_sequencer

Interface
REQ-001 Parameter DEPTH, default 32: instruction-memory word count, power of two; all PC arithmetic is modulo DEPTH.
REQ-002 Parameter START_ADDR, default 0: PC value loaded at reset.
REQ-003 clk  in  1  single clock; all state updates on rising edge.
REQ-004 reset  in  1  synchronous, active-low reset (0 = reset asserted), sampled on clk rising edge.
REQ-005 en  in  1  fetch enable; 1 = sequencer runs.
REQ-006 direinstru  out  32  word address to the instruction memory.
REQ-007 instru  in  32  instruction word returned combinationally for direinstru.
REQ-008 if_instr  out  32  registered instruction to the decode stage.
REQ-009 if_pc  out  32  address of if_instr.
REQ-010 if_valid  out  1  if_instr/if_pc hold a live instruction.
REQ-011 id_ready  in  1  decode accepts; transfer occurs when if_valid & id_ready.
REQ-012 br_taken  in  1  one-cycle redirect request from execute.
REQ-013 br_target  in  32  redirect word address, valid with br_taken.
REQ-014 pd_jump  out  1  predecoded-jump indicator (see Configuration).
REQ-015 fetch_count  out  16  count of completed decode transfers.
REQ-016 state  out  2  FSM state: 00 IDLE, 01 RUN, 10 HOLD, 11 REDIRECT.

Function
REQ-017 direinstru SHALL equal the internal pc register, zero-extended, with no combinational path from any input.
REQ-018 Capture condition: state RUN or HOLD, en=1, br_taken=0, and (if_valid=0 or id_ready=1); on capture if_instr<=instru, if_pc<=pc, if_valid<=1, pc<=(pc+1) mod DEPTH.
REQ-019 IDLE: if_valid cleared on id_ready=1 when set; no capture; en=1 -> RUN next cycle.
REQ-020 RUN: capture per REQ-018; if_valid=1 and id_ready=0 -> HOLD, with if_instr, if_pc and pc unchanged.
REQ-021 HOLD: all outputs stable; id_ready=1 -> capture and return to RUN.
REQ-022 en=0 in RUN or HOLD -> IDLE; no further captures; a pending if_valid is retained until id_ready=1.
REQ-023 br_taken=1 in any state except IDLE SHALL have highest priority: pc<=br_target mod DEPTH, if_valid<=0 (squash regardless of id_ready), state -> REDIRECT.
REQ-024 REDIRECT: lasts exactly one cycle with if_valid=0, then RUN if en=1, otherwise IDLE; br_taken in REDIRECT re-applies REQ-023.
REQ-025 Redirect penalty: first target instruction SHALL appear on if_valid two cycles after the br_taken cycle.
REQ-026 fetch_count SHALL increment by 1 on each cycle with if_valid=1 and id_ready=1, wrapping from 0xFFFF to 0; a squashed instruction is never counted.
REQ-027 pc wrap: pc=DEPTH-1 capture -> pc=0.

Reset
REQ-028 reset=0 at a clock edge SHALL force: pc=START_ADDR, state=IDLE, if_valid=0, if_instr=0, if_pc=0, pd_jump=0, fetch_count=0; it overrides every other input, including mid-HOLD or mid-REDIRECT.

Configuration
REQ-029 Macro FETCH_PREDECODE_EN defined: on capture, if instru[31:26]=6'b111110, pc<=(pc + sign-extended instru[15:0]) mod DEPTH instead of pc+1; the jump itself is still delivered; pd_jump=1 registered alongside it; no bubble.
REQ-030 Macro undefined: no predecode; pc always advances by 1; pd_jump tied to 0; jumps are resolved only via br_taken.

Verification
REQ-031 Reset: reset=0 for 2 cycles, then 1 with en=0 -> state=00, direinstru=0, if_valid=0, fetch_count=0.
REQ-032 Streaming: en=1, id_ready=1 held, memory words 0..9 -> if_pc 0,1,2,... on consecutive cycles, fetch_count=10 after 10 transfers.
REQ-033 Stall: id_ready=0 for 3 cycles while if_pc=4 -> state=HOLD, if_pc stays 4, direinstru stays 5; id_ready=1 -> if_pc=5 next cycle.
REQ-034 Redirect: br_taken=1 with br_target=2 while if_pc=6 and id_ready=1 -> next cycle if_valid=0, state=REDIRECT; following cycle if_pc=2; fetch_count not incremented for the squashed word.
REQ-035 Wrap and reset: DEPTH=32 run to if_pc=31 -> next if_pc=0; reset=0 asserted during HOLD -> all outputs at reset values the next cycle.
REQ-036 Predecode (macro on): word 0xF8000002 at address 9 -> pd_jump=1 with if_pc=9; next if_pc=11. Macro off: next if_pc=10, pd_jump=0.

Source files
------------

// File: rtl/fetch_sequencer_if.sv
`default_nettype none
// ============================================================================
// Module      : fetch_sequencer_if
// Description : Instruction-memory bus, decode handshake and redirect bundle
//               between the fetch sequencer and its surroundings.
// Revision    : 1.0 - initial release
// ============================================================================
interface fetch_sequencer_if;
    logic [31:0] direinstru;   // word address to instruction memory
    logic [31:0] instru;       // instruction word for direinstru
    logic [31:0] if_instr;     // registered instruction to decode
    logic [31:0] if_pc;        // address of if_instr
    logic        if_valid;     // if_instr/if_pc hold a live instruction
    logic        id_ready;     // decode accepts
    logic        br_taken;     // one-cycle redirect request
    logic [31:0] br_target;    // redirect word address
    logic        pd_jump;      // predecoded-jump indicator

    modport master (
        output direinstru,
        input  instru,
        output if_instr,
        output if_pc,
        output if_valid,
        output pd_jump,
        input  id_ready,
        input  br_taken,
        input  br_target
    );

    modport slave (
        input  direinstru,
        output instru,
        input  if_instr,
        input  if_pc,
        input  if_valid,
        input  pd_jump,
        output id_ready,
        output br_taken,
        output br_target
    );
endinterface
`default_nettype wire

// File: rtl/fetch_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : fetch_sequencer
// Description : Instruction fetch sequencer. Walks the PC through a DEPTH-word
//               instruction memory, registers one instruction per cycle into
//               a valid/ready handshake toward decode, stalls on back-pressure
//               and takes one-cycle redirects from execute.
//               Optional macro FETCH_PREDECODE_EN: predecodes opcode 6'b111110
//               as a PC-relative jump and follows it with no bubble.
// Revision    : 1.0 - initial release
// ============================================================================
module fetch_sequencer #(
    parameter int unsigned DEPTH      = 32,   // power of two, >= 2
    parameter int unsigned START_ADDR = 0
) (
    input  wire logic         clk,
    input  wire logic         reset,          // synchronous, active low
    input  wire logic         en,
    fetch_sequencer_if.master bus,
    output logic [15:0]       fetch_count,
    output logic [1:0]        state
);

    localparam int ADDR_W = $clog2(DEPTH);

    typedef enum logic [1:0] {
        S_IDLE     = 2'b00,
        S_RUN      = 2'b01,
        S_HOLD     = 2'b10,
        S_REDIRECT = 2'b11
    } state_t;

    state_t              r_state;
    state_t              w_state_nxt;
    logic [ADDR_W-1:0]   r_pc;
    logic [31:0]         r_if_instr;
    logic [31:0]         r_if_pc;
    logic                r_if_valid;
    logic                r_pd_jump;
    logic [15:0]         r_fetch_count;

    logic                w_capture;    // load instru into the decode register
    logic                w_squash;     // redirect: drop the live instruction
    logic                w_xfer;       // counted decode transfer
    logic                w_is_jump;
    logic [ADDR_W-1:0]   w_pc_adv;     // pc after a capture
    logic [31:0]         w_pc_ext;

    assign w_pc_ext = 32'(r_pc);

`ifdef FETCH_PREDECODE_EN
    logic [31:0] w_offset;
    logic [31:0] w_jump_sum;
    logic        w_unused;

    assign w_offset   = {{16{bus.instru[15]}}, bus.instru[15:0]};
    assign w_jump_sum = w_pc_ext + w_offset;
    assign w_is_jump  = (bus.instru[31:26] == 6'b111110);
    // Follow the jump directly; the jump word itself is still delivered.
    assign w_pc_adv   = w_is_jump ? w_jump_sum[ADDR_W-1:0] : r_pc + ADDR_W'(1);
    assign w_unused   = &{1'b0, bus.br_target, w_jump_sum};
`else
    logic        w_unused;

    assign w_is_jump  = 1'b0;
    assign w_pc_adv   = r_pc + ADDR_W'(1);
    assign w_unused   = &{1'b0, bus.br_target};
`endif

    // Next-state and capture/squash decisions; redirect has top priority.
    always_comb begin
        w_state_nxt = r_state;
        w_capture   = 1'b0;
        w_squash    = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (en) begin
                    w_state_nxt = S_RUN;
                end
            end
            S_RUN, S_HOLD: begin
                if (bus.br_taken) begin
                    w_squash    = 1'b1;
                    w_state_nxt = S_REDIRECT;
                end else if (!en) begin
                    w_state_nxt = S_IDLE;
                end else if (!r_if_valid || bus.id_ready) begin
                    w_capture   = 1'b1;
                    w_state_nxt = S_RUN;
                end else begin
                    w_state_nxt = S_HOLD;
                end
            end
            S_REDIRECT: begin
                // The redirect cycle already fetches the target word so it
                // is on if_valid two cycles after br_taken.
                if (bus.br_taken) begin
                    w_squash    = 1'b1;
                    w_state_nxt = S_REDIRECT;
                end else if (en) begin
                    w_capture   = 1'b1;
                    w_state_nxt = S_RUN;
                end else begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // A squashed instruction is never handed to decode, so never counted.
    assign w_xfer = r_if_valid & bus.id_ready & ~w_squash;

    // State register.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // PC, decode register and transfer counter.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_pc          <= ADDR_W'(START_ADDR);
            r_if_instr    <= '0;
            r_if_pc       <= '0;
            r_if_valid    <= 1'b0;
            r_pd_jump     <= 1'b0;
            r_fetch_count <= '0;
        end else begin
            if (w_squash) begin
                r_pc <= bus.br_target[ADDR_W-1:0];
            end else if (w_capture) begin
                r_pc <= w_pc_adv;
            end

            if (w_capture) begin
                r_if_instr <= bus.instru;
                r_if_pc    <= w_pc_ext;
            end

            if (w_squash) begin
                r_if_valid <= 1'b0;
                r_pd_jump  <= 1'b0;
            end else if (w_capture) begin
                r_if_valid <= 1'b1;
                r_pd_jump  <= w_is_jump;
            end else if (w_xfer) begin
                r_if_valid <= 1'b0;
                r_pd_jump  <= 1'b0;
            end

            if (w_xfer) begin
                r_fetch_count <= r_fetch_count + 16'd1;
            end
        end
    end

    assign bus.direinstru = w_pc_ext;
    assign bus.if_instr   = r_if_instr;
    assign bus.if_pc      = r_if_pc;
    assign bus.if_valid   = r_if_valid;
    assign bus.pd_jump    = r_pd_jump;
    assign fetch_count    = r_fetch_count;
    assign state          = r_state;

endmodule
`default_nettype wire

// File: tb/tb_fetch_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_fetch_sequencer
// Description : Directed, table-driven bench for fetch_sequencer with a
//               combinational instruction-memory model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fetch_sequencer;

    localparam int DEPTH = 32;
`ifdef FETCH_PREDECODE_EN
    localparam int PD_ON = 1;
`else
    localparam int PD_ON = 0;
`endif
    // if_pc that follows the word at address 9 (a jump by +2 when predecoded)
    localparam int JN = (PD_ON != 0) ? 11 : 10;

    logic        clk = 1'b0;
    logic        reset;
    logic        en;
    logic [15:0] fetch_count;
    logic [1:0]  state;
    logic [31:0] mem [DEPTH];

    int n_cmp = 0;
    int n_err = 0;

    fetch_sequencer_if bus();

    fetch_sequencer #(
        .DEPTH      (DEPTH),
        .START_ADDR (0)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .en          (en),
        .bus         (bus),
        .fetch_count (fetch_count),
        .state       (state)
    );

    always #5 clk = ~clk;

    assign bus.instru = mem[bus.direinstru[4:0]];

    typedef struct {
        logic        en;
        logic        rdy;
        logic        br;
        logic [31:0] tgt;
        logic [1:0]  st;
        logic        vld;
        logic [31:0] ifpc;
        logic [31:0] dir;
        logic [15:0] cnt;
        logic        pd;
    } vec_t;

    vec_t tbl[$];

    task automatic add(input int e, input int r, input int b, input int t,
                       input int st, input int vld, input int ifpc,
                       input int dir, input int cnt, input int pd);
        vec_t v;
        v.en   = e[0];
        v.rdy  = r[0];
        v.br   = b[0];
        v.tgt  = 32'(t);
        v.st   = st[1:0];
        v.vld  = vld[0];
        v.ifpc = 32'(ifpc);
        v.dir  = 32'(dir);
        v.cnt  = cnt[15:0];
        v.pd   = pd[0];
        tbl.push_back(v);
    endtask

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic step(input logic e, input logic r, input logic b,
                        input logic [31:0] t);
        en            = e;
        bus.id_ready  = r;
        bus.br_taken  = b;
        bus.br_target = t;
        @(posedge clk);
        #1;
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, " state"},       32'(state),        32'd0);
        check({tag, " direinstru"},  bus.direinstru,    32'd0);
        check({tag, " if_valid"},    32'(bus.if_valid), 32'd0);
        check({tag, " if_instr"},    bus.if_instr,      32'd0);
        check({tag, " if_pc"},       bus.if_pc,         32'd0);
        check({tag, " pd_jump"},     32'(bus.pd_jump),  32'd0);
        check({tag, " fetch_count"}, 32'(fetch_count),  32'd0);
    endtask

    initial begin
        for (int i = 0; i < DEPTH; i++) begin
            mem[i] = 32'hA000_0000 | 32'(i);
        end
        mem[9] = 32'hF800_0002;

        //   en rdy br tgt   st vld ifpc   dir     cnt pd
        add(1, 1, 0, 0,     1, 0, 0,     0,      0,  0);   // IDLE -> RUN
        add(1, 1, 0, 0,     1, 1, 0,     1,      0,  0);   // first capture
        add(1, 1, 0, 0,     1, 1, 1,     2,      1,  0);
        add(1, 1, 0, 0,     1, 1, 2,     3,      2,  0);
        add(1, 1, 0, 0,     1, 1, 3,     4,      3,  0);
        add(1, 1, 0, 0,     1, 1, 4,     5,      4,  0);
        add(1, 0, 0, 0,     2, 1, 4,     5,      4,  0);   // stall at if_pc 4
        add(1, 0, 0, 0,     2, 1, 4,     5,      4,  0);
        add(1, 0, 0, 0,     2, 1, 4,     5,      4,  0);
        add(1, 1, 0, 0,     1, 1, 5,     6,      5,  0);   // release
        add(1, 1, 0, 0,     1, 1, 6,     7,      6,  0);
        add(1, 1, 0, 0,     1, 1, 7,     8,      7,  0);
        add(1, 1, 0, 0,     1, 1, 8,     9,      8,  0);
        add(1, 1, 0, 0,     1, 1, 9,     JN,     9,  PD_ON); // jump word
        add(1, 1, 0, 0,     1, 1, JN,    JN + 1, 10, 0);   // 10 transfers
        add(1, 1, 1, 2,     3, 0, JN,    2,      10, 0);   // redirect
        add(1, 1, 0, 0,     1, 1, 2,     3,      10, 0);   // target 2 cycles on
        add(1, 1, 0, 0,     1, 1, 3,     4,      11, 0);
        add(1, 1, 0, 0,     1, 1, 4,     5,      12, 0);
        add(1, 1, 0, 0,     1, 1, 5,     6,      13, 0);
        add(1, 1, 0, 0,     1, 1, 6,     7,      14, 0);
        add(1, 1, 1, 2,     3, 0, 6,     2,      14, 0);   // squash if_pc 6
        add(1, 1, 1, 35,    3, 0, 6,     3,      14, 0);   // re-redirect, mod 32
        add(1, 1, 0, 0,     1, 1, 3,     4,      14, 0);
        add(0, 0, 0, 0,     0, 1, 3,     4,      14, 0);   // en=0 keeps pending
        add(0, 0, 1, 7,     0, 1, 3,     4,      14, 0);   // br ignored in IDLE
        add(0, 1, 0, 0,     0, 0, 3,     4,      15, 0);   // drained in IDLE
        add(1, 1, 0, 0,     1, 0, 3,     4,      15, 0);
        add(1, 1, 0, 0,     1, 1, 4,     5,      15, 0);
        add(0, 0, 1, 9,     3, 0, 4,     9,      15, 0);   // br beats en=0
        add(0, 0, 0, 0,     0, 0, 4,     9,      15, 0);   // REDIRECT -> IDLE

        // Reset: two cycles low, then released with en=0
        reset         = 1'b0;
        en            = 1'b0;
        bus.id_ready  = 1'b0;
        bus.br_taken  = 1'b0;
        bus.br_target = '0;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b1;
        @(posedge clk);
        #1;
        check_reset_values("reset");

        foreach (tbl[i]) begin
            step(tbl[i].en, tbl[i].rdy, tbl[i].br, tbl[i].tgt);
            check($sformatf("v%0d state", i),       32'(state),        32'(tbl[i].st));
            check($sformatf("v%0d if_valid", i),    32'(bus.if_valid), 32'(tbl[i].vld));
            check($sformatf("v%0d if_pc", i),       bus.if_pc,         tbl[i].ifpc);
            check($sformatf("v%0d direinstru", i),  bus.direinstru,    tbl[i].dir);
            check($sformatf("v%0d fetch_count", i), 32'(fetch_count),  32'(tbl[i].cnt));
            check($sformatf("v%0d pd_jump", i),     32'(bus.pd_jump),  32'(tbl[i].pd));
            if (tbl[i].vld) begin
                check($sformatf("v%0d if_instr", i), bus.if_instr, mem[tbl[i].ifpc[4:0]]);
            end
        end

        // PC wrap: redirect to 29 and stream across the end of memory
        step(1'b1, 1'b1, 1'b0, 32'd0);
        check("wrap run", 32'(state), 32'd1);
        step(1'b1, 1'b1, 1'b1, 32'd29);
        check("wrap redirect dir", bus.direinstru, 32'd29);
        step(1'b1, 1'b1, 1'b0, 32'd0);
        step(1'b1, 1'b1, 1'b0, 32'd0);
        step(1'b1, 1'b1, 1'b0, 32'd0);
        check("wrap if_pc 31", bus.if_pc, 32'd31);
        check("wrap dir 0", bus.direinstru, 32'd0);
        step(1'b1, 1'b1, 1'b0, 32'd0);
        check("wrap if_pc 0", bus.if_pc, 32'd0);
        check("wrap if_instr", bus.if_instr, mem[0]);
        check("wrap dir 1", bus.direinstru, 32'd1);

        // Reset asserted mid-HOLD overrides every other input
        step(1'b1, 1'b0, 1'b0, 32'd0);
        check("hold state", 32'(state), 32'd2);
        check("hold if_valid", 32'(bus.if_valid), 32'd1);
        reset = 1'b0;
        step(1'b1, 1'b1, 1'b1, 32'd5);
        check_reset_values("reset in hold");
        reset = 1'b1;
        step(1'b1, 1'b1, 1'b0, 32'd0);
        check("post reset state", 32'(state), 32'd1);
        check("post reset dir", bus.direinstru, 32'd0);
        step(1'b1, 1'b1, 1'b0, 32'd0);
        check("post reset if_pc", bus.if_pc, 32'd0);
        check("post reset if_valid", 32'(bus.if_valid), 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
